// File: rtl/tbman_print_arb.sv
// Print arbiter: per-requester byte FIFOs feeding tbman PRINT over APB, with a per-line lock.
// Optional lock-release timeout compiled in with `define TBMAN_PRINT_ARB_TIMEOUT_EN.
module tbman_print_arb #(
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] PRINT_ADDR = 16'h0000,
    parameter int unsigned TIMEOUT    = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 apbm_psel,
    output logic                 apbm_penable,
    output logic                 apbm_pwrite,
    output logic [15:0]          apbm_paddr,
    output logic [31:0]          apbm_pwdata,
    input  logic                 apbm_pready,
    input  logic                 apbm_pslverr,
    output logic                 busy,
    output logic                 err,
    output logic                 timeout
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef logic [IW-1:0] id_t;
    typedef logic [AW:0]   ptr_t;
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

    if (N_REQ < 1 || N_REQ > 8 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
        $error("tbman_print_arb: illegal parameter combination");
    end

    state_t     state_q, state_d;
    logic [7:0] mem_q [N_REQ][FIFO_DEPTH];
    logic [7:0] mem_d [N_REQ][FIFO_DEPTH];
    ptr_t       wr_ptr_q [N_REQ];
    ptr_t       wr_ptr_d [N_REQ];
    ptr_t       rd_ptr_q [N_REQ];
    ptr_t       rd_ptr_d [N_REQ];
    logic       lock_valid_q, lock_valid_d;
    id_t        lock_id_q, lock_id_d;
    id_t        last_grant_q, last_grant_d;
    id_t        sel_q, sel_d;
    logic [7:0] data_q, data_d;
    logic       err_q, err_d;

    logic [N_REQ-1:0] empty, full, push, ne_post;
    logic             done, go;
    id_t              ch;

`ifdef TBMAN_PRINT_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          tmo_q, tmo_d;
`endif

    // Eligible-channel pick: locked owner only, else round-robin starting after last.
    function automatic logic pick(input logic [N_REQ-1:0] ne, input logic lv,
                                  input id_t lid, input id_t last, output id_t sel);
        int unsigned idx;
        pick = 1'b0;
        sel  = last;
        if (lv) begin
            pick = ne[lid];
            sel  = lid;
        end else begin
            for (int unsigned i = 1; i <= N_REQ; i++) begin
                idx = (32'(last) + i) % N_REQ;
                for (int unsigned j = 0; j < N_REQ; j++) begin
                    if (!pick && j == idx && ne[j]) begin
                        pick = 1'b1;
                        sel  = id_t'(j);
                    end
                end
            end
        end
    endfunction

    always_comb begin
        for (int unsigned k = 0; k < N_REQ; k++) begin
            empty[k] = (wr_ptr_q[k] == rd_ptr_q[k]);
            full[k]  = (wr_ptr_q[k][AW] != rd_ptr_q[k][AW]) &&
                       (wr_ptr_q[k][AW-1:0] == rd_ptr_q[k][AW-1:0]);
            push[k]  = req_valid[k] && !full[k];
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        lock_valid_d = lock_valid_q;
        lock_id_d    = lock_id_q;
        last_grant_d = last_grant_q;
        sel_d        = sel_q;
        data_d       = data_q;
        err_d        = 1'b0;
        ch           = last_grant_q;
        go           = 1'b0;
        ne_post      = '0;
        done         = (state_q == S_ACCESS) && apbm_pready;

        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (push[k]) begin
                mem_d[k][wr_ptr_q[k][AW-1:0]] = req_data[8*k +: 8];
                wr_ptr_d[k] = wr_ptr_q[k] + ptr_t'(1);
            end
        end

`ifdef TBMAN_PRINT_ARB_TIMEOUT_EN
        tmo_cnt_d = '0;
        tmo_d     = 1'b0;
        if (lock_valid_q && empty[lock_id_q] && state_q == S_IDLE && !push[lock_id_q]) begin
            if (tmo_cnt_q == CW'(TIMEOUT - 1)) begin
                lock_valid_d = 1'b0;
                tmo_d        = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + CW'(1);
            end
        end
`endif

        if (done) begin
            rd_ptr_d[sel_q] = rd_ptr_q[sel_q] + ptr_t'(1);
            err_d           = apbm_pslverr;
            if (data_q == 8'h0A) begin
                lock_valid_d = 1'b0;
            end else begin
                lock_valid_d = 1'b1;
                lock_id_d    = sel_q;
            end
        end

        // Eligibility looks at occupancy after this cycle's pop and the updated lock.
        for (int unsigned k = 0; k < N_REQ; k++) begin
            ne_post[k] = (rd_ptr_d[k] != wr_ptr_q[k]);
        end
        if (state_q == S_IDLE || done) begin
            go = pick(ne_post, lock_valid_d, lock_id_d, last_grant_q, ch);
        end

        unique case (state_q)
            S_IDLE:   if (go) state_d = S_SETUP;
            S_SETUP:  state_d = S_ACCESS;
            S_ACCESS: if (done) state_d = go ? S_SETUP : S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (go) begin
            sel_d        = ch;
            last_grant_d = ch;
            data_d       = mem_q[ch][rd_ptr_d[ch][AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '{default: '0};
            rd_ptr_q     <= '{default: '0};
            lock_valid_q <= 1'b0;
            lock_id_q    <= '0;
            last_grant_q <= id_t'(N_REQ - 1);
            sel_q        <= '0;
            data_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            lock_valid_q <= lock_valid_d;
            lock_id_q    <= lock_id_d;
            last_grant_q <= last_grant_d;
            sel_q        <= sel_d;
            data_q       <= data_d;
            err_q        <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef TBMAN_PRINT_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_q     <= tmo_d;
        end
    end
    assign timeout = tmo_q;
`else
    assign timeout = 1'b0;
`endif

    assign req_ready    = ~full;
    assign apbm_psel    = (state_q != S_IDLE);
    assign apbm_penable = (state_q == S_ACCESS);
    assign apbm_pwrite  = apbm_psel;
    assign apbm_paddr   = PRINT_ADDR;
    assign apbm_pwdata  = {24'h0, data_q};
    assign busy         = (|(~empty)) || apbm_psel;
    assign err          = err_q;

endmodule

// File: tb/tb_tbman_print_arb.sv
// Directed bench for tbman_print_arb: reset, single byte, line lock, round-robin,
// back-pressure, slave error and lock hold (timeout when the macro is defined).
module tb_tbman_print_arb;
    localparam int unsigned N    = 3;
    localparam logic [15:0] ADDR = 16'hA5C0;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           apbm_psel, apbm_penable, apbm_pwrite;
    logic [15:0]    apbm_paddr;
    logic [31:0]    apbm_pwdata;
    logic           apbm_pready, apbm_pslverr;
    logic           busy, err, timeout;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [7:0] log_b[$];
    int         log_c[$];

    tbman_print_arb #(
        .N_REQ      (N),
        .FIFO_DEPTH (4),
        .PRINT_ADDR (ADDR),
        .TIMEOUT    (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .apbm_psel    (apbm_psel),
        .apbm_penable (apbm_penable),
        .apbm_pwrite  (apbm_pwrite),
        .apbm_paddr   (apbm_paddr),
        .apbm_pwdata  (apbm_pwdata),
        .apbm_pready  (apbm_pready),
        .apbm_pslverr (apbm_pslverr),
        .busy         (busy),
        .err          (err),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    // Record every completed APB write and the channel that owned it.
    always @(posedge clk) begin
        if (!rst && apbm_psel && apbm_penable && apbm_pready) begin
            log_b.push_back(apbm_pwdata[7:0]);
            log_c.push_back(int'(dut.sel_q));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        req_valid    = '0;
        req_data     = '0;
        apbm_pready  = 1'b1;
        apbm_pslverr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        log_b.delete();
        log_c.delete();
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget && busy; i++) tick();
        chk(tag, busy, 0);
    endtask

    task automatic chk_log(input string tag, input string exp);
        chk(tag, log_b.size(), exp.len());
        for (int i = 0; i < exp.len(); i++) begin
            if (i < log_b.size()) chk(tag, log_b[i], exp[i]);
        end
    endtask

    initial begin
        int   k;
        int   tmo_at;
        logic acc;

        // Reset values
        do_reset();
        chk("rst_psel", apbm_psel, 0);
        chk("rst_penable", apbm_penable, 0);
        chk("rst_pwrite", apbm_pwrite, 0);
        chk("rst_pwdata", apbm_pwdata, 0);
        chk("rst_paddr", apbm_paddr, ADDR);
        chk("rst_ready", req_ready, 3'b111);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_timeout", timeout, 0);

        // Single byte: accepted at edge n, SETUP at n+1, ACCESS at n+2, done at n+3
        req_valid = 3'b001;
        req_data  = {16'h0, 8'h41};
        tick();
        req_valid = '0;
        chk("single_busy_pending", busy, 1);
        chk("single_idle_psel", apbm_psel, 0);
        tick();
        chk("single_setup_psel", apbm_psel, 1);
        chk("single_setup_penable", apbm_penable, 0);
        chk("single_setup_pwrite", apbm_pwrite, 1);
        chk("single_setup_pwdata", apbm_pwdata, 32'h41);
        chk("single_setup_paddr", apbm_paddr, ADDR);
        tick();
        chk("single_access_penable", apbm_penable, 1);
        chk("single_access_pwdata", apbm_pwdata, 32'h41);
        tick();
        chk("single_done_psel", apbm_psel, 0);
        chk("single_done_busy", busy, 0);
        chk_log("single_log", "A");

        // Line atomicity: both channels push a line in the same cycles
        do_reset();
        req_valid = 3'b011;
        req_data  = {8'h00, "x", "A"};
        tick();
        req_data  = {8'h00, "y", "B"};
        tick();
        req_data  = {8'h00, 8'h0A, 8'h0A};
        tick();
        req_valid = '0;
        wait_drain("line_drain", 60);
        chk_log("line_log", "AB\nxy\n");

        // Round-robin with every channel pushing newlines
        do_reset();
        req_valid = 3'b111;
        req_data  = {3{8'h0A}};
        repeat (14) tick();
        req_valid = '0;
        wait_drain("rr_drain", 100);
        chk("rr_count", log_c.size() >= 6, 1);
        for (int i = 0; i < 6; i++) begin
            if (i < log_c.size()) chk("rr_grant", log_c[i], i % 3);
        end

        // Back-pressure: slave stalls while ch0 keeps pushing
        do_reset();
        apbm_pready = 1'b0;
        k = 0;
        for (int c = 0; c < 20; c++) begin
            req_valid = 3'b001;
            req_data  = {16'h0, 8'h10 + 8'(k)};
            acc = req_ready[0];
            tick();
            if (acc) k++;
        end
        chk("bp_accepted", k, 4);
        chk("bp_ready_low", req_ready[0], 0);
        chk("bp_stall_penable", apbm_penable, 1);
        chk("bp_stall_pwdata", apbm_pwdata, 32'h10);
        apbm_pready = 1'b1;
        for (int c = 0; c < 40 && k < 8; c++) begin
            req_valid = 3'b001;
            req_data  = {16'h0, 8'h10 + 8'(k)};
            acc = req_ready[0];
            tick();
            if (acc) k++;
        end
        req_valid = '0;
        wait_drain("bp_drain", 60);
        chk("bp_log_len", log_b.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < log_b.size()) chk("bp_log", log_b[i], 8'h10 + 8'(i));
        end

        // Slave error on the second byte of "AB\n"
        do_reset();
        req_valid = 3'b001;
        req_data  = {16'h0, 8'h41};
        tick();
        req_data  = {16'h0, 8'h42};
        tick();
        req_data  = {16'h0, 8'h0A};
        tick();
        req_valid = '0;
        tick();
        tick();
        chk("slverr_access_b", apbm_pwdata, 32'h42);
        chk("slverr_err_before", err, 0);
        apbm_pslverr = 1'b1;
        tick();
        apbm_pslverr = 1'b0;
        chk("slverr_err_pulse", err, 1);
        chk("slverr_lock_valid", dut.lock_valid_q, 1);
        chk("slverr_lock_id", dut.lock_id_q, 0);
        tick();
        chk("slverr_err_single", err, 0);
        wait_drain("slverr_drain", 40);
        chk_log("slverr_log", "AB\n");

        // Lock held by ch0 after "A"; ch1 waits behind it
        do_reset();
        req_valid = 3'b011;
        req_data  = {8'h00, "z", "A"};
        tick();
        req_valid = '0;
        tmo_at = -1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (timeout && tmo_at < 0) tmo_at = c;
        end
`ifdef TBMAN_PRINT_ARB_TIMEOUT_EN
        chk("tmo_pulse_cycle", tmo_at, 18);
        chk_log("tmo_log", "Az");
`else
        chk("tmo_never", tmo_at, -1);
        chk_log("tmo_log", "A");
        chk("tmo_busy_held", busy, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
